alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001 Parameter: STARVE_LIMIT, default 4, count of consecutive lost arbitrations after which requester 1 is forced to win (fixed-priority build only).
- REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
- REQ-003 resetn_i  in  1  reset, asynchronous assert, active-low.
- REQ-004 r0_valid_i / r1_valid_i  in  1  requester 0/1 has an operation pending.
- REQ-005 r0_ready_o / r1_ready_o  out  1  requester 0/1 operation accepted this cycle.
- REQ-006 r0_op1_i, r0_op2_i, r1_op1_i, r1_op2_i  in  32 (data_bus)  operands.
- REQ-007 r0_func_i, r1_func_i  in  4  ALU function code, passed unmodified to the ALU.
- REQ-008 alu_op1_o, alu_op2_o  out  32  operands to the shared ALU.
- REQ-009 alu_func_o  out  4  function code to the shared ALU.
- REQ-010 alu_d_i  in  32, alu_zero_i  in  1, alu_lt_i  in  1  ALU outputs.
- REQ-011 rsp_valid_o  out  2  one-hot; bit k marks the result as belonging to requester k.
- REQ-012 rsp_ready_i  in  2  bit k: requester k consumes the result.
- REQ-013 rsp_d_o  out  32, rsp_zero_o  out  1, rsp_lt_o  out  1  registered result.

Function
- REQ-014 FSM states: IDLE, EXEC, RESP; reset state IDLE.
- REQ-015 IDLE: if any valid is high, the arbiter grants one requester combinationally, asserts only that requester's ready, latches its op1/op2/func and index, and moves to EXEC; with no valid, it stays in IDLE.
- REQ-016 In any state other than IDLE, both ready outputs are 0.
- REQ-017 EXEC: the latched operands and func drive alu_*_o; at the clock edge, alu_d_i/zero/lt are captured into the result registers; the FSM then moves to RESP.
- REQ-018 In IDLE and RESP, alu_*_o hold the last latched values (no glitching to requester inputs).
- REQ-019 RESP: rsp_valid_o[g]=1 for granted g, other bit 0; the result holds stable until rsp_ready_i[g]=1, at which point the FSM moves to IDLE; rsp_ready_i of the non-granted bit is ignored.
- REQ-020 Latency: accept at cycle N gives rsp_valid at N+2; with ready held high, the minimum issue interval is 3 cycles.
- REQ-021 Default arbitration is round-robin: on a simultaneous request, the requester not granted last wins; the last-grant pointer resets to 1 (so requester 0 wins first) and updates only on a grant.
- REQ-022 A single requester is granted regardless of the pointer.
- REQ-023 A requester whose valid drops while in EXEC/RESP does not affect the in-flight operation.

Reset
- REQ-024 Asserting resetn_i low at any time aborts any in-flight operation immediately: state IDLE, ready outputs 0, rsp_valid_o 2'b00, rsp_d_o 0, rsp_zero_o 0, rsp_lt_o 0, alu_op1_o/op2_o 0, alu_func_o 0, grant pointer 1, starvation counter 0.
- REQ-025 The first grant may occur in the first rising edge after deassertion.

Configuration
- REQ-026 Macro ALU_ARB_FIXED_PRIO_EN; when it is defined, requester 0 wins every simultaneous request, except that after STARVE_LIMIT consecutive arbitrations lost by a pending requester 1, requester 1 wins the next one; the counter clears on any grant to requester 1.
- REQ-027 When ALU_ARB_FIXED_PRIO_EN is undefined, round-robin per REQ-021 applies and no starvation counter is instantiated.

Verification
- REQ-028 r0 only, op1=0x12345678, op2=0xFEDCBA98, func=1, rsp_ready=2'b01 -> r0_ready at N, rsp_valid=2'b01 at N+2, rsp_d=0x11111110.
- REQ-029 r0 and r1 both valid continuously (round-robin build), r0 func=2, r1 func=1, same operands -> grants alternate r0,r1,r0; r0 results 0x13579BE0, r1 results 0x11111110.
- REQ-030 In RESP, hold rsp_ready_i=2'b00 for 5 cycles -> rsp_valid and rsp_d are stable, both readies are 0, and there is no new grant; setting rsp_ready_i=2'b10 while granted to r0 causes no transition.
- REQ-031 Reset pulsed low in EXEC -> all outputs are 0 in the same cycle; after release with r0 and r1 both valid, r0 is granted first.
- REQ-032 ALU_ARB_FIXED_PRIO_EN defined, STARVE_LIMIT=4, both requesters valid -> grant sequence r0,r0,r0,r0,r1,r0,...
- REQ-033 Mid-operation r1_valid toggles and r0 operands change during EXEC -> the captured result matches the operands latched at grant.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// A three-state FSM (IDLE -> EXEC -> RESP) accepts one operation at a time,
// presents the latched operands to the ALU for one cycle, registers the
// result and holds it until the owning requester consumes it.
// Build option: define ALU_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority to requester 0 plus a starvation escape for requester 1.
module alu_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        r0_valid_i,
    input  logic        r1_valid_i,
    output logic        r0_ready_o,
    output logic        r1_ready_o,
    input  logic [31:0] r0_op1_i,
    input  logic [31:0] r0_op2_i,
    input  logic [31:0] r1_op1_i,
    input  logic [31:0] r1_op2_i,
    input  logic [3:0]  r0_func_i,
    input  logic [3:0]  r1_func_i,
    output logic [31:0] alu_op1_o,
    output logic [31:0] alu_op2_o,
    output logic [3:0]  alu_func_o,
    input  logic [31:0] alu_d_i,
    input  logic        alu_zero_i,
    input  logic        alu_lt_i,
    output logic [1:0]  rsp_valid_o,
    input  logic [1:0]  rsp_ready_i,
    output logic [31:0] rsp_d_o,
    output logic        rsp_zero_o,
    output logic        rsp_lt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_idx_q;      // requester owning the in-flight operation
    logic        last_q;         // requester granted most recently
    logic [31:0] op1_q, op2_q;
    logic [3:0]  func_q;
    logic [31:0] rsp_d_q;
    logic        rsp_zero_q, rsp_lt_q;

    logic        gnt;            // winner of the current arbitration
    logic        accept;         // an operation is taken this cycle
    logic        capture;        // ALU result is registered this cycle

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_q;

    // Fixed priority to requester 0 unless requester 1 has lost too often.
    always_comb begin
        gnt = 1'b0;
        if (r0_valid_i && r1_valid_i) begin
            gnt = (starve_q == CNT_W'(STARVE_LIMIT));
        end else if (r1_valid_i) begin
            gnt = 1'b1;
        end
    end

    // Count consecutive arbitrations lost by a pending requester 1.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            starve_q <= '0;
        end else if (accept) begin
            if (gnt) begin
                starve_q <= '0;
            end else if (r1_valid_i && (starve_q != CNT_W'(STARVE_LIMIT))) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT > 0);

    // Round-robin: on a tie the requester not granted last wins.
    always_comb begin
        gnt = 1'b0;
        if (r0_valid_i && r1_valid_i) begin
            gnt = ~last_q;
        end else if (r1_valid_i) begin
            gnt = 1'b1;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, handshake outputs and datapath enables.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        capture     = 1'b0;
        r0_ready_o  = 1'b0;
        r1_ready_o  = 1'b0;
        rsp_valid_o = 2'b00;
        case (state_q)
            IDLE: begin
                // Gate with reset so no handshake is seen while reset is held.
                if ((r0_valid_i || r1_valid_i) && resetn_i) begin
                    accept     = 1'b1;
                    r0_ready_o = ~gnt;
                    r1_ready_o = gnt;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = gnt_idx_q ? 2'b10 : 2'b01;
                if (rsp_ready_i[gnt_idx_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the winner's operation and remember who was granted.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            op1_q     <= '0;
            op2_q     <= '0;
            func_q    <= '0;
            gnt_idx_q <= 1'b0;
            last_q    <= 1'b1;
        end else if (accept) begin
            op1_q     <= gnt ? r1_op1_i : r0_op1_i;
            op2_q     <= gnt ? r1_op2_i : r0_op2_i;
            func_q    <= gnt ? r1_func_i : r0_func_i;
            gnt_idx_q <= gnt;
            last_q    <= gnt;
        end
    end

    // Register the ALU result at the end of EXEC.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rsp_d_q    <= '0;
            rsp_zero_q <= 1'b0;
            rsp_lt_q   <= 1'b0;
        end else if (capture) begin
            rsp_d_q    <= alu_d_i;
            rsp_zero_q <= alu_zero_i;
            rsp_lt_q   <= alu_lt_i;
        end
    end

    assign alu_op1_o  = op1_q;
    assign alu_op2_o  = op2_q;
    assign alu_func_o = func_q;
    assign rsp_d_o    = rsp_d_q;
    assign rsp_zero_o = rsp_zero_q;
    assign rsp_lt_o   = rsp_lt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small ALU model
// (func 1 = add, func 2 = subtract, otherwise AND; lt is a signed compare).
module tb_alu_arbiter;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        r0_valid_i, r1_valid_i;
    logic        r0_ready_o, r1_ready_o;
    logic [31:0] r0_op1_i, r0_op2_i, r1_op1_i, r1_op2_i;
    logic [3:0]  r0_func_i, r1_func_i;
    logic [31:0] alu_op1_o, alu_op2_o;
    logic [3:0]  alu_func_o;
    logic [31:0] alu_d_i;
    logic        alu_zero_i, alu_lt_i;
    logic [1:0]  rsp_valid_o;
    logic [1:0]  rsp_ready_i;
    logic [31:0] rsp_d_o;
    logic        rsp_zero_o, rsp_lt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    alu_arbiter dut (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .r0_valid_i  (r0_valid_i),
        .r1_valid_i  (r1_valid_i),
        .r0_ready_o  (r0_ready_o),
        .r1_ready_o  (r1_ready_o),
        .r0_op1_i    (r0_op1_i),
        .r0_op2_i    (r0_op2_i),
        .r1_op1_i    (r1_op1_i),
        .r1_op2_i    (r1_op2_i),
        .r0_func_i   (r0_func_i),
        .r1_func_i   (r1_func_i),
        .alu_op1_o   (alu_op1_o),
        .alu_op2_o   (alu_op2_o),
        .alu_func_o  (alu_func_o),
        .alu_d_i     (alu_d_i),
        .alu_zero_i  (alu_zero_i),
        .alu_lt_i    (alu_lt_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_d_o     (rsp_d_o),
        .rsp_zero_o  (rsp_zero_o),
        .rsp_lt_o    (rsp_lt_o)
    );

    // Shared ALU model.
    always_comb begin
        case (alu_func_o)
            4'd1:    alu_d_i = alu_op1_o + alu_op2_o;
            4'd2:    alu_d_i = alu_op1_o - alu_op2_o;
            default: alu_d_i = alu_op1_o & alu_op2_o;
        endcase
    end
    assign alu_zero_i = (alu_d_i == 32'd0);
    assign alu_lt_i   = ($signed(alu_op1_o) < $signed(alu_op2_o));

    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        r0_valid_i = 1'b0; r1_valid_i = 1'b0;
        r0_op1_i = '0; r0_op2_i = '0; r1_op1_i = '0; r1_op2_i = '0;
        r0_func_i = '0; r1_func_i = '0; rsp_ready_i = 2'b00;
    endtask

    task automatic do_reset();
        next_cycle();
        resetn_i = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        resetn_i = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn_i = 1'b0;
        r0_valid_i = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        checks++; if (r0_ready_o !== 1'b0) begin errors++; $display("FAIL rst_r0_ready got %b want 0", r0_ready_o); end
        checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b want 00", rsp_valid_o); end
        checks++; if (rsp_d_o !== 32'd0) begin errors++; $display("FAIL rst_rsp_d got %h want 0", rsp_d_o); end
        checks++; if (alu_op1_o !== 32'd0 || alu_func_o !== 4'd0) begin errors++; $display("FAIL rst_alu got %h/%h want 0/0", alu_op1_o, alu_func_o); end
        next_cycle();
        resetn_i = 1'b1;
        #1;
        checks++; if (r0_ready_o !== 1'b1) begin errors++; $display("FAIL rst_first_grant got %b want 1", r0_ready_o); end
    endtask

    task automatic test_single();
        do_reset();
        r0_valid_i = 1'b1; r0_op1_i = 32'h12345678; r0_op2_i = 32'hFEDCBA98;
        r0_func_i = 4'd1; rsp_ready_i = 2'b01;
        #1;
        checks++; if ({r0_ready_o, r1_ready_o} !== 2'b10) begin errors++; $display("FAIL single_ready got %b want 10", {r0_ready_o, r1_ready_o}); end
        next_cycle();
        r0_valid_i = 1'b0;
        #1;
        checks++; if ({r0_ready_o, r1_ready_o, rsp_valid_o} !== 4'b0000) begin errors++; $display("FAIL single_exec_hs got %b want 0000", {r0_ready_o, r1_ready_o, rsp_valid_o}); end
        checks++; if ({alu_op1_o, alu_op2_o, alu_func_o} !== {32'h12345678, 32'hFEDCBA98, 4'd1}) begin errors++; $display("FAIL single_alu got %h %h %h want 12345678 fedcba98 1", alu_op1_o, alu_op2_o, alu_func_o); end
        next_cycle();
        #1;
        checks++; if (rsp_valid_o !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b want 01", rsp_valid_o); end
        checks++; if (rsp_d_o !== 32'h11111110) begin errors++; $display("FAIL single_rsp_d got %h want 11111110", rsp_d_o); end
        checks++; if ({rsp_zero_o, rsp_lt_o} !== 2'b00) begin errors++; $display("FAIL single_flags got %b want 00", {rsp_zero_o, rsp_lt_o}); end
        next_cycle();
        #1;
        checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL single_done got %b want 00", rsp_valid_o); end
    endtask

    task automatic test_arbitration();
`ifdef ALU_ARB_FIXED_PRIO_EN
        int seq [6] = '{0, 0, 0, 0, 1, 0};
`else
        int seq [6] = '{0, 1, 0, 1, 0, 1};
`endif
        do_reset();
        r0_valid_i = 1'b1; r1_valid_i = 1'b1;
        r0_op1_i = 32'h12345678; r0_op2_i = 32'hFEDCBA98; r0_func_i = 4'd2;
        r1_op1_i = 32'h12345678; r1_op2_i = 32'hFEDCBA98; r1_func_i = 4'd1;
        rsp_ready_i = 2'b11;
        for (int i = 0; i < 6; i++) begin
            logic [1:0]  exp_rdy;
            logic [1:0]  exp_vld;
            logic [31:0] exp_d;
            exp_rdy = (seq[i] == 1) ? 2'b01 : 2'b10;
            exp_vld = (seq[i] == 1) ? 2'b10 : 2'b01;
            exp_d   = (seq[i] == 1) ? 32'h11111110 : 32'h13579BE0;
            #1;
            checks++; if ({r0_ready_o, r1_ready_o} !== exp_rdy) begin errors++; $display("FAIL arb_grant[%0d] got %b want %b", i, {r0_ready_o, r1_ready_o}, exp_rdy); end
            next_cycle();
            next_cycle();
            #1;
            checks++; if (rsp_valid_o !== exp_vld || rsp_d_o !== exp_d) begin errors++; $display("FAIL arb_rsp[%0d] got %b/%h want %b/%h", i, rsp_valid_o, rsp_d_o, exp_vld, exp_d); end
            next_cycle();
        end
    endtask

    task automatic test_hold();
        logic [1:0] exp_rdy;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_rdy = 2'b10;
`else
        exp_rdy = 2'b01;
`endif
        do_reset();
        r0_valid_i = 1'b1; r1_valid_i = 1'b1;
        r0_op1_i = 32'h12345678; r0_op2_i = 32'hFEDCBA98; r0_func_i = 4'd1;
        r1_op1_i = 32'h1; r1_op2_i = 32'h1; r1_func_i = 4'd1;
        rsp_ready_i = 2'b00;
        #1;
        checks++; if ({r0_ready_o, r1_ready_o} !== 2'b10) begin errors++; $display("FAIL hold_grant got %b want 10", {r0_ready_o, r1_ready_o}); end
        next_cycle();
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (rsp_valid_o !== 2'b01 || rsp_d_o !== 32'h11111110 || {r0_ready_o, r1_ready_o} !== 2'b00) begin
                errors++; $display("FAIL hold_stable[%0d] got %b/%h/%b want 01/11111110/00", i, rsp_valid_o, rsp_d_o, {r0_ready_o, r1_ready_o});
            end
            next_cycle();
        end
        rsp_ready_i = 2'b10;
        next_cycle();
        #1;
        checks++; if (rsp_valid_o !== 2'b01 || rsp_d_o !== 32'h11111110) begin errors++; $display("FAIL hold_wrong_ready got %b/%h want 01/11111110", rsp_valid_o, rsp_d_o); end
        rsp_ready_i = 2'b01;
        next_cycle();
        #1;
        checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL hold_release got %b want 00", rsp_valid_o); end
        checks++; if ({r0_ready_o, r1_ready_o} !== exp_rdy) begin errors++; $display("FAIL hold_next_grant got %b want %b", {r0_ready_o, r1_ready_o}, exp_rdy); end
    endtask

    task automatic test_reset_exec();
        do_reset();
        r0_valid_i = 1'b1; r0_op1_i = 32'h12345678; r0_op2_i = 32'hFEDCBA98;
        r0_func_i = 4'd1; rsp_ready_i = 2'b01;
        next_cycle();
        next_cycle();
        next_cycle();
        #1;
        checks++; if (r0_ready_o !== 1'b1) begin errors++; $display("FAIL rexec_second_grant got %b want 1", r0_ready_o); end
        next_cycle();
        #1;
        checks++; if (alu_op1_o !== 32'h12345678 || rsp_d_o !== 32'h11111110) begin errors++; $display("FAIL rexec_pre got %h/%h want 12345678/11111110", alu_op1_o, rsp_d_o); end
        resetn_i = 1'b0;
        r1_valid_i = 1'b1; r1_op1_i = 32'h5; r1_op2_i = 32'h5; r1_func_i = 4'd1;
        #1;
        checks++; if ({r0_ready_o, r1_ready_o, rsp_valid_o} !== 4'b0000) begin errors++; $display("FAIL rexec_hs got %b want 0000", {r0_ready_o, r1_ready_o, rsp_valid_o}); end
        checks++; if (rsp_d_o !== 32'd0 || rsp_zero_o !== 1'b0 || rsp_lt_o !== 1'b0) begin errors++; $display("FAIL rexec_rsp got %h/%b/%b want 0/0/0", rsp_d_o, rsp_zero_o, rsp_lt_o); end
        checks++; if (alu_op1_o !== 32'd0 || alu_op2_o !== 32'd0 || alu_func_o !== 4'd0) begin errors++; $display("FAIL rexec_alu got %h/%h/%h want 0/0/0", alu_op1_o, alu_op2_o, alu_func_o); end
        next_cycle();
        resetn_i = 1'b1;
        #1;
        checks++; if ({r0_ready_o, r1_ready_o} !== 2'b10) begin errors++; $display("FAIL rexec_first_after got %b want 10", {r0_ready_o, r1_ready_o}); end
    endtask

    task automatic test_flags();
        do_reset();
        r1_valid_i = 1'b1; r1_op1_i = 32'd3; r1_op2_i = 32'd5; r1_func_i = 4'd2;
        rsp_ready_i = 2'b10;
        #1;
        checks++; if ({r0_ready_o, r1_ready_o} !== 2'b01) begin errors++; $display("FAIL flags_grant got %b want 01", {r0_ready_o, r1_ready_o}); end
        next_cycle();
        next_cycle();
        #1;
        checks++; if (rsp_valid_o !== 2'b10 || rsp_d_o !== 32'hFFFFFFFE || {rsp_zero_o, rsp_lt_o} !== 2'b01) begin
            errors++; $display("FAIL flags_lt got %b/%h/%b want 10/fffffffe/01", rsp_valid_o, rsp_d_o, {rsp_zero_o, rsp_lt_o});
        end
        r1_op1_i = 32'd7; r1_op2_i = 32'd7;
        next_cycle();
        next_cycle();
        next_cycle();
        #1;
        checks++; if (rsp_valid_o !== 2'b10 || rsp_d_o !== 32'd0 || {rsp_zero_o, rsp_lt_o} !== 2'b10) begin
            errors++; $display("FAIL flags_zero got %b/%h/%b want 10/00000000/10", rsp_valid_o, rsp_d_o, {rsp_zero_o, rsp_lt_o});
        end
    endtask

    task automatic test_midop();
        do_reset();
        r0_valid_i = 1'b1; r0_op1_i = 32'd100; r0_op2_i = 32'd58; r0_func_i = 4'd2;
        rsp_ready_i = 2'b01;
        #1;
        checks++; if (r0_ready_o !== 1'b1) begin errors++; $display("FAIL midop_grant got %b want 1", r0_ready_o); end
        next_cycle();
        r0_op1_i = 32'd999; r0_op2_i = 32'd1; r0_func_i = 4'd1; r1_valid_i = 1'b1;
        #1;
        checks++; if (alu_op1_o !== 32'd100 || alu_op2_o !== 32'd58 || alu_func_o !== 4'd2) begin errors++; $display("FAIL midop_alu got %h/%h/%h want 64/3a/2", alu_op1_o, alu_op2_o, alu_func_o); end
        next_cycle();
        r1_valid_i = 1'b0;
        #1;
        checks++; if (rsp_valid_o !== 2'b01 || rsp_d_o !== 32'd42) begin errors++; $display("FAIL midop_rsp got %b/%h want 01/0000002a", rsp_valid_o, rsp_d_o); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout reached got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_hold();
        test_reset_exec();
        test_flags();
        test_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
